// File: rtl/cover_toggle_collector.sv
// Toggle coverage collector: records first hits on WIDTH cover points into a
// sticky bitmap and emits one event per newly covered point through a
// single-slot valid/ready output, lowest-numbered pending point first.
module cover_toggle_collector #(
    parameter int unsigned WIDTH      = 28,
    parameter int unsigned BASE_INDEX = 0,
    parameter int unsigned IDX_W      = 16,
    localparam int unsigned CNT_W     = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] valid,
    input  logic             clear,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [IDX_W-1:0] evt_index,
    output logic [WIDTH-1:0] covered,
    output logic [CNT_W-1:0] covered_count,
    output logic             all_covered
);

    localparam int unsigned SEL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] covered_q;
    logic [WIDTH-1:0] pending_q;
    logic [WIDTH-1:0] pending_d;
    logic [WIDTH-1:0] new_hits;
    logic [WIDTH-1:0] sel_onehot;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] new_count;
    logic [SEL_W-1:0] sel;
    logic [IDX_W-1:0] next_index;
    logic [IDX_W-1:0] evt_index_q;
    logic             evt_valid_q;
    logic             have_pending;
    logic             slot_free;
    logic             take;

    // First hits only: bits already covered are masked so they change no state.
    always_comb begin
        new_hits  = valid & ~covered_q;
        new_count = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            new_count = new_count + CNT_W'(new_hits[i]);
        end
    end

    // Pick the lowest-numbered pending point and work out what the slot does.
    always_comb begin
        logic found;
        found        = 1'b0;
        sel          = '0;
        have_pending = |pending_q;
        // Two's-complement trick isolates the lowest set bit.
        sel_onehot   = pending_q & (~pending_q + 1'b1);
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (pending_q[i] && !found) begin
                found = 1'b1;
                sel   = SEL_W'(i);
            end
        end
        next_index = IDX_W'(BASE_INDEX) + IDX_W'(sel);
        slot_free  = !evt_valid_q || evt_ready;
        take       = slot_free && have_pending;
        // A new hit can never collide with the taken bit: pending is a subset of covered.
        pending_d  = (pending_q & ~(take ? sel_onehot : '0)) | new_hits;
    end

    // Coverage state and event slot; reset beats clear, clear beats everything else.
    always_ff @(posedge clock) begin
        if (!reset) begin
            covered_q   <= '0;
            pending_q   <= '0;
            count_q     <= '0;
            evt_valid_q <= 1'b0;
            evt_index_q <= '0;
        end else if (clear) begin
            covered_q   <= '0;
            pending_q   <= '0;
            count_q     <= '0;
            evt_valid_q <= 1'b0;
            evt_index_q <= '0;
        end else begin
            covered_q <= covered_q | new_hits;
            pending_q <= pending_d;
            count_q   <= count_q + new_count;
            if (slot_free) begin
                evt_valid_q <= have_pending;
                if (have_pending) begin
                    evt_index_q <= next_index;
                end
            end
        end
    end

    assign covered       = covered_q;
    assign covered_count = count_q;
    assign all_covered   = (count_q == CNT_W'(WIDTH));
    assign evt_valid     = evt_valid_q;
    assign evt_index     = evt_index_q;

endmodule

// File: tb/tb_cover_toggle_collector.sv
// Directed bench for cover_toggle_collector: a default instance plus one with
// BASE_INDEX=9000, both driven from the same stimulus.
module tb_cover_toggle_collector;

    logic        clock;
    logic        reset;
    logic [27:0] valid;
    logic        clear;
    logic        evt_ready;

    logic        evt_valid;
    logic [15:0] evt_index;
    logic [27:0] covered;
    logic [4:0]  covered_count;
    logic        all_covered;

    logic        evt_valid_b;
    logic [15:0] evt_index_b;
    logic [27:0] covered_b;
    logic [4:0]  covered_count_b;
    logic        all_covered_b;

    int n_checks = 0;
    int n_pass   = 0;
    int n_events = 0;

    cover_toggle_collector dut (
        .clock         (clock),
        .reset         (reset),
        .valid         (valid),
        .clear         (clear),
        .evt_valid     (evt_valid),
        .evt_ready     (evt_ready),
        .evt_index     (evt_index),
        .covered       (covered),
        .covered_count (covered_count),
        .all_covered   (all_covered)
    );

    cover_toggle_collector #(
        .BASE_INDEX (9000)
    ) dut_b (
        .clock         (clock),
        .reset         (reset),
        .valid         (valid),
        .clear         (clear),
        .evt_valid     (evt_valid_b),
        .evt_ready     (evt_ready),
        .evt_index     (evt_index_b),
        .covered       (covered_b),
        .covered_count (covered_count_b),
        .all_covered   (all_covered_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_covered"}, 32'(covered), 32'h0);
        chk({tag, "_count"}, 32'(covered_count), 32'h0);
        chk({tag, "_evt_valid"}, 32'(evt_valid), 32'h0);
        chk({tag, "_evt_index"}, 32'(evt_index), 32'h0);
        chk({tag, "_all_covered"}, 32'(all_covered), 32'h0);
    endtask

    initial begin
        reset     = 1'b0;
        clear     = 1'b0;
        valid     = '0;
        evt_ready = 1'b0;
        // Reset is honoured even with valid high.
        valid = 28'hFFFFFFF;
        tick();
        valid = '0;
        tick();
        chk_idle("reset");
        reset = 1'b1;

        // Two hits in one cycle, consumer always ready.
        evt_ready = 1'b1;
        valid     = 28'h0000005;
        tick();
        valid = '0;
        chk("basic_covered", 32'(covered), 32'h5);
        chk("basic_count", 32'(covered_count), 32'd2);
        chk("basic_latency", 32'(evt_valid), 32'h0);
        tick();
        chk("basic_ev0_valid", 32'(evt_valid), 32'h1);
        chk("basic_ev0_index", 32'(evt_index), 32'd0);
        tick();
        chk("basic_ev1_valid", 32'(evt_valid), 32'h1);
        chk("basic_ev1_index", 32'(evt_index), 32'd2);
        tick();
        chk("basic_drained", 32'(evt_valid), 32'h0);

        // Backpressure: event 7 must hold while ready is low.
        evt_ready = 1'b0;
        valid     = 28'h0000080;
        tick();
        valid = 28'h0000008;
        tick();
        valid = '0;
        for (int i = 0; i < 10; i++) begin
            chk("stall_valid", 32'(evt_valid), 32'h1);
            chk("stall_index", 32'(evt_index), 32'd7);
            tick();
        end
        chk("stall_hold_index", 32'(evt_index), 32'd7);
        evt_ready = 1'b1;
        tick();
        chk("stall_next_valid", 32'(evt_valid), 32'h1);
        chk("stall_next_index", 32'(evt_index), 32'd3);
        tick();
        chk("stall_drained", 32'(evt_valid), 32'h0);
        chk("stall_covered", 32'(covered), 32'h8D);
        chk("stall_count", 32'(covered_count), 32'd4);

        // Offset index and repeated hit on bit 27.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk_idle("clear0");
        chk("clear0_b_count", 32'(covered_count_b), 32'd0);
        valid = 28'h8000000;
        tick();
        chk("rep_count_b", 32'(covered_count_b), 32'd1);
        chk("rep_latency_b", 32'(evt_valid_b), 32'h0);
        valid = '0;
        tick();
        chk("rep_index_b", 32'(evt_index_b), 32'd9027);
        chk("rep_index", 32'(evt_index), 32'd27);
        if (evt_valid_b) n_events++;
        valid = 28'h8000000;
        tick();
        valid = '0;
        for (int i = 0; i < 4; i++) begin
            if (evt_valid_b) n_events++;
            tick();
        end
        chk("rep_one_event_b", 32'(n_events), 32'd1);
        chk("rep_count_b_after", 32'(covered_count_b), 32'd1);
        chk("rep_covered_b", 32'(covered_b), 32'h8000000);

        // Every point in one cycle: 28 back-to-back events.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        valid = 28'hFFFFFFF;
        tick();
        valid = '0;
        chk("full_count", 32'(covered_count), 32'd28);
        chk("full_all_covered", 32'(all_covered), 32'h1);
        chk("full_all_covered_b", 32'(all_covered_b), 32'h1);
        for (int i = 0; i < 28; i++) begin
            tick();
            chk("full_ev_valid", 32'(evt_valid), 32'h1);
            chk("full_ev_index", 32'(evt_index), 32'(i));
        end
        tick();
        chk("full_drained", 32'(evt_valid), 32'h0);
        chk("full_still_all", 32'(all_covered), 32'h1);

        // Clear while an event is presented and five more are pending.
        clear = 1'b1;
        tick();
        clear     = 1'b0;
        evt_ready = 1'b0;
        valid     = 28'h000007D;
        tick();
        valid = '0;
        tick();
        chk("clr_pre_valid", 32'(evt_valid), 32'h1);
        chk("clr_pre_index", 32'(evt_index), 32'd0);
        clear     = 1'b1;
        valid     = 28'h0000002;
        evt_ready = 1'b1;
        tick();
        clear = 1'b0;
        valid = '0;
        chk_idle("clr_post");
        tick();
        tick();
        chk("clr_no_leftover", 32'(evt_valid), 32'h0);
        valid = 28'h0000002;
        tick();
        valid = '0;
        tick();
        chk("clr_bit1_valid", 32'(evt_valid), 32'h1);
        chk("clr_bit1_index", 32'(evt_index), 32'd1);
        chk("clr_bit1_covered", 32'(covered), 32'h2);

        // Reset in the middle of a 10-event drain.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        valid = 28'h00003FF;
        tick();
        valid = '0;
        tick();
        tick();
        tick();
        chk("rst_mid_index", 32'(evt_index), 32'd2);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk_idle("rst_mid");
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rst_no_events", 32'(evt_valid), 32'h0);
        end
        chk("rst_covered_stays", 32'(covered), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cover_toggle_collector.md
COVER_TOGGLE_COLLECTOR -- requirements
Module: cover_toggle_collector

Interface
REQ-001 SHALL have parameter WIDTH, default 28: number of toggle cover points per instance.
REQ-002 SHALL have parameter BASE_INDEX, default 0: global cover index of bit 0.
REQ-003 SHALL have parameter IDX_W, default 16: width of the reported cover index.
REQ-004 SHALL have port clock  input  1: clock; all state is updated on the rising edge.
REQ-005 SHALL have port reset  input  1: reset, synchronous, active-low.
REQ-006 SHALL have port valid  input  WIDTH: per-point toggle hit strobes, sampled every cycle.
REQ-007 SHALL have port clear  input  1: synchronous clear of all coverage state.
REQ-008 SHALL have port evt_valid  output  1: a first-hit event is presented.
REQ-009 SHALL have port evt_ready  input  1: the consumer accepts the presented event.
REQ-010 SHALL have port evt_index  output  IDX_W: BASE_INDEX + bit number of the newly covered point.
REQ-011 SHALL have port covered  output  WIDTH: sticky hit bitmap.
REQ-012 SHALL have port covered_count  output  clog2(WIDTH+1): population count of covered.
REQ-013 SHALL have port all_covered  output  1: high when covered_count == WIDTH.

Function
REQ-014 SHALL compute new = valid & ~covered; at each edge with reset high and clear low, covered |= new, pending |= new, and covered_count += popcount(new).
REQ-015 SHALL update covered and covered_count combinationally from registers, so a hit sampled at edge N is visible in the cycle after edge N.
REQ-016 SHALL report each cover point at most once between clears; a repeated hit on a covered bit SHALL change no state.
REQ-017 SHALL hold event output state in a single register slot; the slot is free when evt_valid is low or when evt_valid && evt_ready.
REQ-018 SHALL, at an edge where the slot is free and pending is non-zero, load the lowest-numbered pending bit into the slot, set evt_valid, and clear that bit from pending.
REQ-019 SHALL load the slot only from pending as registered before the edge; a hit at edge N produces evt_valid no earlier than after edge N+1 (2-cycle min latency).
REQ-020 SHALL keep evt_valid low after a handshake when pending is empty at that edge.
REQ-021 SHALL hold evt_index stable while evt_valid && !evt_ready; evt_valid SHALL NOT drop without a handshake, except on clear or reset.
REQ-022 SHALL sustain one event per cycle while evt_ready is held high and pending is non-empty.
REQ-023 SHALL form evt_index as BASE_INDEX + bit, truncated to IDX_W bits.
REQ-024 SHALL give clear priority over all else: at an edge with clear high, covered, pending, covered_count and evt_valid go to 0, and valid bits sampled that cycle are discarded.
REQ-025 SHALL treat an event held in the slot during clear as dropped, even if evt_ready is high in the same cycle.
REQ-026 SHALL not overflow covered_count: count <= WIDTH by construction, since each bit is counted once.
REQ-027 SHALL accept any valid pattern, including all WIDTH bits in one cycle.

Reset
REQ-028 SHALL, at an edge with reset low, set covered = 0, pending = 0, covered_count = 0, evt_valid = 0, evt_index = 0, and all_covered = 0; reset overrides clear and valid.
REQ-029 SHALL behave after reset release identically to the state after clear.

Verification
REQ-030 Bench SHALL drive, with evt_ready=1: valid=28'h0000005 for 1 cycle -> covered=5 and count=2 the next cycle; events index 0 then 2 on consecutive cycles; evt_valid then 0.
REQ-031 Bench SHALL hold evt_ready=0, pulse valid bit 7 and then bit 3 -> evt_index=7 held stable for 10 cycles; raising evt_ready yields 7 then 3.
REQ-032 Bench SHALL, with BASE_INDEX=9000, hit bit 27 twice -> exactly one event, evt_index=9027, count=1.
REQ-033 Bench SHALL drive valid=all ones for 1 cycle with evt_ready=1 -> count=28, all_covered=1, events 0..27 in order over 28 consecutive cycles.
REQ-034 Bench SHALL assert clear while evt_valid=1 with 5 pending and valid bit 1 high -> next cycle all outputs 0; bit 1 is not recorded; hitting bit 1 later reports it again.
REQ-035 Bench SHALL assert reset mid-drain of a 10-event burst -> all outputs 0 the next cycle and no further events.
